mod_tx: RTL and testbench

MOD_TX -- requirements
Module: mod_tx

---
 rtl/mod_pkg.sv | 22 ++
 rtl/carrier_gen.sv | 48 ++++
 rtl/mod_tx.sv | 157 +++++++++++++++
 tb/tb_mod_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared definitions for the modulating transmitter.
//   mode_t  : 2-bit modulation select as seen on the mode input
//   state_t : transmit FSM states
//   CNT_W   : width of the carrier half-period counter
package mod_pkg;

    typedef enum logic [1:0] {
        MODE_ASK = 2'b00,
        MODE_FSK = 2'b01,
        MODE_PSK = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/carrier_gen.sv
// Square-wave carrier generator.
//   clk     : system clock
//   rst     : asynchronous active-low reset, clears counter and carrier
//   clr     : synchronous clear, restarts the carrier at phase 0 (bit start)
//   use_f0  : select the F0 (lower frequency) half-period instead of F1
//   carrier : carrier output, toggles every half-period
module carrier_gen
    import mod_pkg::*;
#(
    parameter int F1_HALF = 1250,
    parameter int F0_HALF = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic use_f0,
    output logic carrier
);

    localparam logic [CNT_W-1:0] F1_LAST = CNT_W'(F1_HALF - 1);
    localparam logic [CNT_W-1:0] F0_LAST = CNT_W'(F0_HALF - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] half_last;
    logic             carrier_reg;

    assign half_last = use_f0 ? F0_LAST : F1_LAST;

    // ">=" rather than "==" so a half-period switch mid-count can never
    // let the counter run past its terminal value and wrap through 2^16.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            carrier_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg     <= '0;
            carrier_reg <= 1'b0;
        end else if (cnt_reg >= half_last) begin
            cnt_reg     <= '0;
            carrier_reg <= ~carrier_reg;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign carrier = carrier_reg;

endmodule

// File: rtl/mod_tx.sv
// Word-serial ASK/FSK/PSK modulating transmitter.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   clk_div    : bit-rate square wave; each rising edge is one bit tick
//   mode       : modulation select (ASK, FSK, PSK, reserved)
//   data       : word to transmit, MSB first
//   data_valid : data/mode valid
//   data_ready : word accepted on a cycle where data_valid and data_ready
//   busy       : word in flight (waiting for alignment or sending)
//   bit_out    : bit currently being transmitted (0 when not sending)
//   mod_out    : modulated carrier output (0 when not sending)
module mod_tx
    import mod_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int F1_HALF = 1250,
    parameter int F0_HALF = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_div,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              bit_out,
    output logic              mod_out
);

    localparam int                   BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

    state_t                state_reg;
    state_t                state_next;
    mode_t                 mode_q;
    logic                  clk_div_q;
    logic                  tick;
    logic [DATA_W-1:0]     shift_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg;
    logic                  bit_reg;
    logic                  ready_reg;
    logic                  accept;
    logic                  load_first;
    logic                  advance;
    logic                  finish;
    logic                  carrier;
    logic                  carrier_clr;
    logic                  use_f0;

    assign tick   = clk_div & ~clk_div_q;
    assign accept = (state_reg == ST_IDLE) & data_valid & ready_reg;

    // Next-state logic. A tick seen in IDLE is ignored, so a word accepted
    // on a tick cycle waits in ALIGN for the following tick.
    always_comb begin
        state_next = state_reg;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (tick) begin
                    state_next = ST_SEND;
                    load_first = 1'b1;
                end
            end
            ST_SEND: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = ST_IDLE;
                        finish     = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // data_ready is registered so it stays low throughout reset and rises
    // on the first clock edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            clk_div_q <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            clk_div_q <= clk_div;
            ready_reg <= (state_next == ST_IDLE);
        end
    end

    // Shift register holds the not-yet-sent bits left-justified; the MSB
    // is moved into bit_reg at each bit start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg   <= '0;
            mode_q      <= MODE_ASK;
            bit_cnt_reg <= '0;
            bit_reg     <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg <= data;
                mode_q    <= mode_t'(mode);
            end
            if (load_first || advance) begin
                bit_reg     <= shift_reg[DATA_W-1];
                shift_reg   <= shift_reg << 1;
                bit_cnt_reg <= load_first ? '0 : bit_cnt_reg + BIT_CNT_W'(1);
            end
            if (finish) begin
                bit_reg     <= 1'b0;
                bit_cnt_reg <= '0;
            end
        end
    end

    // Restart the carrier at phase 0 on every tick that begins a bit.
    assign carrier_clr = tick & (state_reg != ST_IDLE);
    assign use_f0      = (mode_q == MODE_FSK) & ~bit_reg;

    carrier_gen #(
        .F1_HALF (F1_HALF),
        .F0_HALF (F0_HALF)
    ) u_carrier_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (carrier_clr),
        .use_f0  (use_f0),
        .carrier (carrier)
    );

    always_comb begin
        mod_out = 1'b0;
        if (state_reg == ST_SEND) begin
            case (mode_q)
                MODE_ASK: mod_out = carrier & bit_reg;
                MODE_FSK: mod_out = carrier;
                MODE_PSK: mod_out = carrier ^ ~bit_reg;
                default:  mod_out = 1'b0;
            endcase
        end
    end

    assign data_ready = ready_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign bit_out    = bit_reg;

endmodule

// File: tb/tb_mod_tx.sv
// Self-checking bench for mod_tx with small carrier half-periods and a
// 64-cycle bit period. Expected outputs come from a per-cycle model that
// tracks bit index and cycles since bit start, deriving the carrier as
// (cycles / half) mod 2.
module tb_mod_tx;

    localparam int DW    = 8;
    localparam int F1    = 4;
    localparam int F0    = 8;
    localparam int DIV_P = 64;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          clk_div    = 1'b0;
    logic [1:0]    mode       = 2'd0;
    logic [DW-1:0] data       = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          busy;
    logic          bit_out;
    logic          mod_out;

    int n_checks = 0;
    int n_fail   = 0;
    int word_no  = 0;
    bit div_run  = 1'b1;
    int div_ph   = 0;
    logic tb_div_q;
    logic tb_tick;

    mod_tx #(
        .DATA_W  (DW),
        .F1_HALF (F1),
        .F0_HALF (F0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .mode       (mode),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .bit_out    (bit_out),
        .mod_out    (mod_out)
    );

    always #5 clk = ~clk;

    // Bit-rate square wave, 32 low / 32 high, updated shortly after the edge.
    always @(posedge clk) begin
        #2;
        if (div_run) begin
            div_ph  = (div_ph + 1) % DIV_P;
            clk_div = (div_ph >= DIV_P / 2);
        end
    end

    // tb_tick is high in the cycle after an edge at which clk_div rose.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tb_div_q <= 1'b0;
            tb_tick  <= 1'b0;
        end else begin
            tb_tick  <= clk_div && !tb_div_q;
            tb_div_q <= clk_div;
        end
    end

    // Send one word and check every cycle until it completes.
    // abort_bit >= 0 asserts reset 10 cycles into that bit and returns.
    // stall_bit >= 0 freezes clk_div for 300 cycles 5 cycles into that bit.
    task automatic run_word(input logic [1:0] m, input logic [DW-1:0] d,
                            input bit hold_valid, input bit at_tick,
                            input int abort_bit, input int stall_bit);
        int   phase;
        int   k;
        int   c;
        int   guard;
        int   half;
        int   car;
        int   bitv;
        int   stall_left;
        bit   stalled;
        logic exp_m;
        guard = 0;
        @(negedge clk);
        while (!(data_ready === 1'b1 && (!at_tick || (clk_div && !tb_div_q)))) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                n_checks++; n_fail++;
                $display("FAIL ready_wait: data_ready=%b after %0d cycles, required 1", data_ready, guard);
                return;
            end
        end
        data       = d;
        mode       = m;
        data_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: busy=%b data_ready=%b, required busy=1 data_ready=0", busy, data_ready);
        end
        if (!hold_valid) data_valid = 1'b0;
        phase = 0; k = 0; c = 0; stall_left = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 2000 && phase != 2; cyc++) begin
            data = DW'($urandom);
            mode = 2'($urandom);
            @(posedge clk); #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) div_run = 1'b1;
            end
            if (tb_tick) begin
                if (phase == 0) begin
                    phase = 1; k = 0; c = 0;
                end else begin
                    k++; c = 0;
                    if (k == DW) phase = 2;
                end
            end else begin
                c++;
            end
            if (phase == 2) begin
                n_checks++;
                if (busy !== 1'b0 || data_ready !== 1'b1 || mod_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL word_end: busy=%b data_ready=%b mod_out=%b, required 0 1 0", busy, data_ready, mod_out);
                end
            end else begin
                n_checks++;
                if (busy !== 1'b1 || data_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_flight: phase=%0d bit=%0d busy=%b data_ready=%b, required 1 0", phase, k, busy, data_ready);
                end
                if (phase == 0) begin
                    n_checks++;
                    if (mod_out !== 1'b0) begin
                        n_fail++;
                        $display("FAIL align_mod: mod_out=%b, required 0", mod_out);
                    end
                end else begin
                    bitv = int'(d[DW-1-k]);
                    half = (m == 2'd1 && bitv == 0) ? F0 : F1;
                    car  = (c / half) % 2;
                    case (m)
                        2'd0:    exp_m = 1'(car & bitv);
                        2'd1:    exp_m = 1'(car);
                        2'd2:    exp_m = 1'(car ^ (1 - bitv));
                        default: exp_m = 1'b0;
                    endcase
                    n_checks++;
                    if (bit_out !== 1'(bitv)) begin
                        n_fail++;
                        $display("FAIL bit_out: bit=%0d cyc=%0d got %b, required %0d", k, c, bit_out, bitv);
                    end
                    n_checks++;
                    if (mod_out !== exp_m) begin
                        n_fail++;
                        $display("FAIL mod_out: mode=%0d bit=%0d cyc=%0d got %b, required %b", m, k, c, mod_out, exp_m);
                    end
                    if (k == abort_bit && c == 10) begin
                        rst = 1'b0;
                        #1;
                        n_checks++;
                        if (data_ready !== 1'b0 || busy !== 1'b0 || bit_out !== 1'b0 || mod_out !== 1'b0) begin
                            n_fail++;
                            $display("FAIL abort_reset: ready=%b busy=%b bit=%b mod=%b, required all 0", data_ready, busy, bit_out, mod_out);
                        end
                        $display("word %0d: mode=%0d data=%02h aborted by reset at bit %0d", word_no, m, d, k);
                        word_no++;
                        return;
                    end
                    if (k == stall_bit && c == 5 && !stalled) begin
                        stalled    = 1'b1;
                        div_run    = 1'b0;
                        stall_left = 300;
                    end
                end
            end
        end
        if (phase != 2) begin
            n_checks++; n_fail++;
            $display("FAIL word_timeout: phase=%0d bit=%0d, required completion", phase, k);
        end
        $display("word %0d: mode=%0d data=%02h sent", word_no, m, d);
        word_no++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (data_ready !== 1'b0 || busy !== 1'b0 || bit_out !== 1'b0 || mod_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b busy=%b bit=%b mod=%b, required all 0", data_ready, busy, bit_out, mod_out);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: data_ready=%b before first edge, required 0", data_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (data_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: data_ready=%b busy=%b, required 1 0", data_ready, busy);
        end
    endtask

    task automatic test_ask();
        run_word(2'b00, 8'hA5, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_fsk();
        repeat (17) @(negedge clk);
        run_word(2'b01, 8'hF0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_psk();
        repeat (5) @(negedge clk);
        run_word(2'b10, 8'h01, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_tick_accept_reserved();
        run_word(2'b11, 8'hC3, 1'b0, 1'b1, -1, -1);
        run_word(2'b00, 8'h96, 1'b0, 1'b1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_word(2'b10, 8'h5A, 1'b1, 1'b0, -1, -1);
        run_word(2'b01, DW'($urandom), 1'b1, 1'b0, -1, -1);
        run_word(2'b00, DW'($urandom), 1'b1, 1'b0, -1, -1);
        data_valid = 1'b0;
    endtask

    task automatic test_stall();
        run_word(2'b01, 8'h6C, 1'b0, 1'b0, -1, 2);
    endtask

    task automatic test_reset_mid();
        run_word(2'b00, 8'hFF, 1'b0, 1'b0, 3, -1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (data_ready !== 1'b0 || busy !== 1'b0 || bit_out !== 1'b0 || mod_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: ready=%b busy=%b bit=%b mod=%b, required all 0", data_ready, busy, bit_out, mod_out);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (data_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ready: data_ready=%b busy=%b, required 1 0", data_ready, busy);
        end
        run_word(2'b10, 8'hB4, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 80)) @(negedge clk);
            run_word(2'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0), -1, -1);
            data_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ask();
        test_fsk();
        test_psk();
        test_tick_accept_reserved();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
